enq_ed_cmd_dispatch: RTL and testbench

//  Consumer stage behind the enq_ed_cmd prefetch FIFO. Pops one enqueue command at a time,

---
 rtl/enq_ed_cmd_dispatch_if.sv | 15 +
 rtl/enq_ed_cmd_dispatch.sv | 132 +++++++++++++
 tb/tb_enq_ed_cmd_dispatch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/enq_ed_cmd_dispatch_if.sv
// Enqueue handshake between the dispatch stage and the queue manager.
//  master (dispatch): drives enq_valid, enq_qid, enq_len; receives enq_ack
//  slave  (queue manager): receives the offer; drives enq_ack
interface enq_ed_cmd_dispatch_if #(
  parameter int QID_NBITS = 5,
  parameter int LEN_NBITS = 14
);
  logic                 enq_valid;
  logic [QID_NBITS-1:0] enq_qid;
  logic [LEN_NBITS-1:0] enq_len;
  logic                 enq_ack;

  modport master (output enq_valid, enq_qid, enq_len, input enq_ack);
  modport slave  (input enq_valid, enq_qid, enq_len, output enq_ack);
endinterface

// File: rtl/enq_ed_cmd_dispatch.sv
// Consumer stage behind the enq_ed_cmd prefetch FIFO. Pops one command at a
// time, checks the per-queue occupancy against MAX_Q_DEPTH, then either drops
// it (counted, saturating) or offers it to the queue manager on valid/ack.
// Occupancy increments on issue and decrements on scheduler dequeue reports.
// Ports:
//  clk, rst              clock, synchronous active-high reset
//  fifo_empty/qid/len    FIFO head (valid while fifo_empty low)
//  fifo_rd               pop strobe (combinational, IDLE only)
//  deq_valid/deq_qid     dequeue report, decrements cnt[deq_qid]
//  enq (master)          enq_valid/enq_qid/enq_len offer, enq_ack accept
//  drop_pulse/drop_count one-cycle drop pulse, saturating drop total
//  dbg_qid/dbg_cnt       combinational occupancy read port
module enq_ed_cmd_dispatch #(
  parameter int QID_NBITS   = 5,
  parameter int LEN_NBITS   = 14,
  parameter int CNT_NBITS   = 10,
  parameter int MAX_Q_DEPTH = 512,
  parameter int DROP_NBITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [QID_NBITS-1:0]   fifo_qid,
  input  logic [LEN_NBITS-1:0]   fifo_len,
  output logic                   fifo_rd,
  input  logic                   deq_valid,
  input  logic [QID_NBITS-1:0]   deq_qid,
  enq_ed_cmd_dispatch_if.master  enq,
  output logic                   drop_pulse,
  output logic [DROP_NBITS-1:0]  drop_count,
  input  logic [QID_NBITS-1:0]   dbg_qid,
  output logic [CNT_NBITS-1:0]   dbg_cnt
);

  localparam int NUM_Q = 2**QID_NBITS;
  localparam logic [CNT_NBITS-1:0] MAX_CNT = CNT_NBITS'(MAX_Q_DEPTH);

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

  state_t               state, state_nxt;
  logic [QID_NBITS-1:0] cmd_qid;
  logic [LEN_NBITS-1:0] cmd_len;
  logic [CNT_NBITS-1:0] cnt [NUM_Q];
  logic [CNT_NBITS-1:0] occ;
  logic                 over;
  logic                 issue_go;
  logic                 drop_go;
  logic [NUM_Q-1:0]     inc_vec;
  logic [NUM_Q-1:0]     dec_vec;

  // Occupancy of the held command, pre-update value of this cycle.
  always_comb begin
    occ  = cnt[cmd_qid];
    over = (occ >= MAX_CNT);
  end

  assign dbg_cnt = cnt[dbg_qid];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = CHECK;
      CHECK:   state_nxt = over ? IDLE : ISSUE;
      ISSUE:   if (enq.enq_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / decision logic
  always_comb begin
    fifo_rd  = (state == IDLE) && !fifo_empty;
    issue_go = (state == CHECK) && !over;
    drop_go  = (state == CHECK) && over;
  end

  // Command hold, offer registers and drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_qid       <= '0;
      cmd_len       <= '0;
      enq.enq_valid <= 1'b0;
      enq.enq_qid   <= '0;
      enq.enq_len   <= '0;
      drop_pulse    <= 1'b0;
      drop_count    <= '0;
    end else begin
      if (fifo_rd) begin
        cmd_qid <= fifo_qid;
        cmd_len <= fifo_len;
      end
      drop_pulse <= drop_go;
      if (drop_go && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      if (issue_go) begin
        enq.enq_valid <= 1'b1;
        enq.enq_qid   <= cmd_qid;
        enq.enq_len   <= cmd_len;
      end else if ((state == ISSUE) && enq.enq_ack) begin
        enq.enq_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      inc_vec[q] = issue_go && (cmd_qid == QID_NBITS'(q));
      dec_vec[q] = deq_valid && (deq_qid == QID_NBITS'(q));
    end
  end

  // Simultaneous increment and decrement on one queue cancel; a decrement
  // of an empty queue is ignored.
  always_ff @(posedge clk) begin
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      if (rst)
        cnt[q] <= '0;
      else if (inc_vec[q] && !dec_vec[q])
        cnt[q] <= cnt[q] + 1'b1;
      else if (dec_vec[q] && !inc_vec[q] && (cnt[q] != '0))
        cnt[q] <= cnt[q] - 1'b1;
    end
  end

endmodule

// File: tb/tb_enq_ed_cmd_dispatch.sv
// Self-checking bench for enq_ed_cmd_dispatch: directed scenarios plus a
// randomized phase checked against an occupancy/drop-count model held in
// plain arrays. Built with MAX_Q_DEPTH=4 and DROP_NBITS=4 so the depth limit
// and drop-counter saturation are reached quickly.
module tb_enq_ed_cmd_dispatch;

  localparam int QW = 5;
  localparam int LW = 14;
  localparam int CW = 10;
  localparam int DW = 4;
  localparam int MAXD = 4;
  localparam int DMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [QW-1:0] fifo_qid = '0;
  logic [LW-1:0] fifo_len = '0;
  logic          fifo_rd;
  logic          deq_valid = 1'b0;
  logic [QW-1:0] deq_qid = '0;
  logic          drop_pulse;
  logic [DW-1:0] drop_count;
  logic [QW-1:0] dbg_qid = '0;
  logic [CW-1:0] dbg_cnt;

  enq_ed_cmd_dispatch_if #(.QID_NBITS(QW), .LEN_NBITS(LW)) enq_if ();

  enq_ed_cmd_dispatch #(
    .QID_NBITS(QW), .LEN_NBITS(LW), .CNT_NBITS(CW),
    .MAX_Q_DEPTH(MAXD), .DROP_NBITS(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_qid(fifo_qid), .fifo_len(fifo_len),
    .fifo_rd(fifo_rd),
    .deq_valid(deq_valid), .deq_qid(deq_qid),
    .enq(enq_if),
    .drop_pulse(drop_pulse), .drop_count(drop_count),
    .dbg_qid(dbg_qid), .dbg_cnt(dbg_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int occ_m [32];
  int dc_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_occ(input logic [QW-1:0] q, input string tag);
    dbg_qid = q;
    #1;
    chk(tag, 32'(dbg_cnt), 32'(occ_m[q]));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) occ_m[i] = 0;
    dc_m = 0;
  endtask

  // One full command: pop, CHECK (optionally with a dequeue report), then
  // either the drop cycle or the offer held for wait_n cycles before ack.
  task automatic run_cmd(input logic [QW-1:0] q, input logic [LW-1:0] l,
                         input int unsigned wait_n, input bit dv,
                         input logic [QW-1:0] dq);
    bit exp_drop;
    fifo_empty = 1'b0; fifo_qid = q; fifo_len = l;
    #1;
    chk("pop_in_idle", 32'(fifo_rd), 32'd1);
    step();
    // CHECK cycle: scramble the FIFO head to prove the command was latched,
    // and offer a stray ack that must be ignored.
    fifo_empty = 1'b1; fifo_qid = QW'($urandom); fifo_len = LW'($urandom);
    deq_valid = dv; deq_qid = dq; enq_if.enq_ack = 1'b1;
    #1;
    chk("no_rd_in_check", 32'(fifo_rd), 32'd0);
    chk("valid_low_check", 32'(enq_if.enq_valid), 32'd0);
    chk("pulse_low_check", 32'(drop_pulse), 32'd0);
    exp_drop = (occ_m[q] >= MAXD);
    if (!exp_drop) occ_m[q]++;
    if (dv && occ_m[dq] > 0) occ_m[dq]--;
    step();
    deq_valid = 1'b0; enq_if.enq_ack = 1'b0;
    if (exp_drop) begin
      dc_m = (dc_m == DMAX) ? DMAX : dc_m + 1;
      chk("drop_pulse", 32'(drop_pulse), 32'd1);
      chk("drop_no_valid", 32'(enq_if.enq_valid), 32'd0);
      chk("drop_count", 32'(drop_count), 32'(dc_m));
    end else begin
      chk("enq_valid", 32'(enq_if.enq_valid), 32'd1);
      chk("enq_qid", 32'(enq_if.enq_qid), 32'(q));
      chk("enq_len", 32'(enq_if.enq_len), 32'(l));
      for (int unsigned i = 0; i < wait_n; i++) begin
        fifo_empty = 1'b0;
        #1;
        chk("no_rd_wait", 32'(fifo_rd), 32'd0);
        step();
        chk("hold_valid", 32'(enq_if.enq_valid), 32'd1);
        chk("hold_qid", 32'(enq_if.enq_qid), 32'(q));
        chk("hold_len", 32'(enq_if.enq_len), 32'(l));
      end
      fifo_empty = 1'b1;
      enq_if.enq_ack = 1'b1;
      step();
      enq_if.enq_ack = 1'b0;
      chk("valid_after_ack", 32'(enq_if.enq_valid), 32'd0);
    end
    check_occ(q, "occ_after_cmd");
  endtask

  task automatic idle_deq(input logic [QW-1:0] q);
    deq_valid = 1'b1; deq_qid = q;
    step();
    deq_valid = 1'b0;
    if (occ_m[q] > 0) occ_m[q]--;
    check_occ(q, "occ_after_deq");
  endtask

  initial begin
    enq_if.enq_ack = 1'b0;
    clear_model();

    // Reset state
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_enq_valid", 32'(enq_if.enq_valid), 32'd0);
    chk("rst_enq_qid", 32'(enq_if.enq_qid), 32'd0);
    chk("rst_enq_len", 32'(enq_if.enq_len), 32'd0);
    chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_fifo_rd_empty", 32'(fifo_rd), 32'd0);
    check_occ(5'd0, "rst_occ0");

    // Single command, zero-wait ack; next pop follows immediately
    run_cmd(5'd3, 14'd64, 0, 1'b0, 5'd0);
    // Ack held off 5 cycles
    run_cmd(5'd5, 14'd100, 5, 1'b0, 5'd0);
    idle_deq(5'd5);

    // Depth limit: 6 commands to qid 7, 4 issued, 2 dropped
    for (int i = 0; i < 6; i++) run_cmd(5'd7, LW'(200 + i), 0, 1'b0, 5'd0);
    chk("t3_drop_count", 32'(drop_count), 32'd2);
    check_occ(5'd7, "t3_occ7");

    // Dequeue on the CHECK edge does not rescue a full queue
    run_cmd(5'd7, 14'd300, 0, 1'b1, 5'd7);
    check_occ(5'd7, "t4_occ7");

    // Same-edge increment and decrement cancel; decrement of empty stays 0
    run_cmd(5'd2, 14'd11, 0, 1'b0, 5'd0);
    run_cmd(5'd2, 14'd12, 1, 1'b1, 5'd2);
    check_occ(5'd2, "t5_occ2");
    idle_deq(5'd9);

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      run_cmd(QW'($urandom_range(0, 7)), LW'($urandom), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), QW'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) idle_deq(QW'($urandom_range(0, 7)));
    end

    // Drop counter saturation
    for (int i = 0; i < 4; i++) run_cmd(5'd10, 14'd1, 0, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++) run_cmd(5'd10, 14'd2, 0, 1'b0, 5'd0);
    chk("drop_saturated", 32'(drop_count), 32'(DMAX));
    for (int i = 0; i < 32; i++) check_occ(QW'(i), "occ_sweep");

    // Reset while an offer is pending
    fifo_empty = 1'b0; fifo_qid = 5'd4; fifo_len = 14'd77;
    step();
    fifo_empty = 1'b1;
    step();
    chk("t6_pending", 32'(enq_if.enq_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    chk("t6_valid", 32'(enq_if.enq_valid), 32'd0);
    chk("t6_drop_count", 32'(drop_count), 32'd0);
    for (int i = 0; i < 32; i++) check_occ(QW'(i), "t6_occ");
    run_cmd(5'd4, 14'd78, 0, 1'b0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
